// File: rtl/seg7_reader_if.sv
// seg7_reader_if
//   Groups the signals of the seven-segment reader into one bundle.
//   master : the observed display and host side; drives seg_n, dig_n, clr and
//            receives the decoded results.
//   slave  : the reader itself; samples seg_n, dig_n, clr and drives
//            value, digit_valid, upd, upd_idx, bad_pattern, err_sticky.
//   seg_n       [6:0]            active-low segments, bit0=a .. bit6=g
//   dig_n       [NUM_DIGITS-1:0] active-low digit selects
//   clr                          clears digit_valid and err_sticky
//   value       [4*NUM_DIGITS-1:0] captured nibbles, digit i at [4i+3:4i]
//   digit_valid [NUM_DIGITS-1:0] per-digit "value holds a captured nibble"
//   upd / upd_idx                one-cycle capture pulse and its digit index
//   bad_pattern / err_sticky     invalid-pattern pulse and its sticky flag
interface seg7_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   dig_n;
    logic                    clr;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    upd;
    logic [2:0]              upd_idx;
    logic                    bad_pattern;
    logic                    err_sticky;

    modport master (
        output seg_n, dig_n, clr,
        input  value, digit_valid, upd, upd_idx, bad_pattern, err_sticky
    );

    modport slave (
        input  seg_n, dig_n, clr,
        output value, digit_valid, upd, upd_idx, bad_pattern, err_sticky
    );
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader
//   Watches a multiplexed seven-segment display and recovers the hex digit
//   shown on each position. The display lines are registered into a sample
//   key; a digit is captured only after the key has been identical for
//   STABLE_CYCLES consecutive samples with exactly one digit select active.
//   Ports:
//     clk  : single rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : seg7_reader_if.slave (display inputs, clr, decoded outputs)
//   All outputs are registered.
module seg7_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    seg7_reader_if.slave bus
);
    localparam int         KEY_W   = NUM_DIGITS + 7;
    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;
    typedef enum logic [1:0] {PAT_HEX, PAT_BLANK, PAT_BAD} pat_t;

    logic [KEY_W-1:0]        key_q;
    logic [KEY_W-1:0]        prev_q;
    state_t                  state_q;
    state_t                  state_d;
    logic [7:0]              run_q;
    logic [7:0]              run_d;
    logic                    capture;

    logic [NUM_DIGITS-1:0]   sel_mask;
    logic [3:0]              zero_cnt;
    logic [2:0]              dig_idx;
    logic                    selectable;
    pat_t                    pat;
    logic [3:0]              nibble;

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic                    upd_q;
    logic [2:0]              upd_idx_q;
    logic                    bad_q;
    logic                    err_q;

    // Sample key and its one-cycle-old copy; every decision below looks only
    // at these registers, never at the raw inputs.
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q  <= '1;
            prev_q <= '1;
        end else begin
            key_q  <= {bus.dig_n, bus.seg_n};
            prev_q <= key_q;
        end
    end

    // Digit select decode: count active (low) selects and remember which one.
    // NOTE: combinational blocks use blocking assignments and give every
    // variable a default first, so no latch is inferred.
    always_comb begin
        sel_mask = ~key_q[KEY_W-1:7];
        zero_cnt = '0;
        dig_idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_mask[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                dig_idx  = 3'(i);
            end
        end
    end

    assign selectable = (zero_cnt == 4'd1);

    // Reverse segment map; anything not listed is an invalid pattern.
    always_comb begin
        pat    = PAT_HEX;
        nibble = 4'h0;
        case (key_q[6:0])
            7'b1000000: nibble = 4'h0;
            7'b1111001: nibble = 4'h1;
            7'b0100100: nibble = 4'h2;
            7'b0110000: nibble = 4'h3;
            7'b0011001: nibble = 4'h4;
            7'b0010010: nibble = 4'h5;
            7'b0000010: nibble = 4'h6;
            7'b1011000: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0010000: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b0000011: nibble = 4'hB;
            7'b1000110: nibble = 4'hC;
            7'b0100001: nibble = 4'hD;
            7'b0000110: nibble = 4'hE;
            7'b0001110: nibble = 4'hF;
            7'b1111111: pat    = PAT_BLANK;
            default:    pat    = PAT_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Run tracking. The capture fires on the same edge the counter reaches
    // RUN_MAX, and DONE then parks the counter so it never passes RUN_MAX.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (selectable) begin
                    state_d = TRACK;
                    run_d   = 8'd1;
                end else begin
                    run_d   = 8'd0;
                end
            end
            TRACK, DONE: begin
                if (key_q != prev_q) begin
                    if (selectable) begin
                        state_d = TRACK;
                        run_d   = 8'd1;
                    end else begin
                        state_d = IDLE;
                        run_d   = 8'd0;
                    end
                end else if (state_q == TRACK) begin
                    run_d = run_q + 8'd1;
                    if (run_d == RUN_MAX) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = 8'd0;
            end
        endcase
    end

    // Output registers. clr is applied first and the capture result after
    // it, so a capture in the same cycle overrides clr for its own digit and
    // a bad pattern keeps err_sticky set.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= '0;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            bad_q <= 1'b0;
            if (bus.clr) begin
                valid_q <= '0;
                err_q   <= 1'b0;
            end
            if (capture) begin
                case (pat)
                    PAT_HEX: begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (sel_mask[i]) begin
                                value_q[4*i +: 4] <= nibble;
                                valid_q[i]        <= 1'b1;
                            end
                        end
                        upd_q     <= 1'b1;
                        upd_idx_q <= dig_idx;
                    end
                    PAT_BLANK: begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (sel_mask[i]) begin
                                valid_q[i] <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        bad_q <= 1'b1;
                        err_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_valid = valid_q;
    assign bus.upd         = upd_q;
    assign bus.upd_idx     = upd_idx_q;
    assign bus.bad_pattern = bad_q;
    assign bus.err_sticky  = err_q;
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader
//   Self-checking bench for seg7_reader (NUM_DIGITS=4, STABLE_CYCLES=4).
//   Expected pulses are queued when a key is driven and popped by a monitor
//   when upd or bad_pattern appears; each test task checks the persistent
//   outputs against a small model held in the bench.
module tb_seg7_reader;
    localparam int ND = 4;
    localparam int S  = 4;

    // kind uses the bit order {upd, bad_pattern}
    typedef struct {
        logic [1:0] kind;
        logic [2:0] idx;
        logic [3:0] nib;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    seg7_reader_if #(.NUM_DIGITS(ND)) bus ();

    seg7_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [4*ND-1:0] value_m;
    logic [ND-1:0]   dv_m;
    logic            err_m;
    logic [ND+6:0]   last_key;

    logic [6:0] hex_seg [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // {kind, nibble}: kind 0 = hex, 1 = blank, 2 = invalid
    function automatic logic [5:0] classify(input logic [6:0] seg);
        logic [5:0] r;
        r = {2'd2, 4'h0};
        for (int n = 0; n < 16; n++) begin
            if (seg == hex_seg[n]) r = {2'd0, 4'(n)};
        end
        if (seg == 7'b1111111) r = {2'd1, 4'h0};
        return r;
    endfunction

    function automatic int single_digit(input logic [ND-1:0] dig);
        int idx;
        int cnt;
        idx = -1;
        cnt = 0;
        for (int i = 0; i < ND; i++) begin
            if (!dig[i]) begin
                cnt++;
                idx = i;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    // Scoreboard monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.upd || bus.bad_pattern) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: upd=%0b bad_pattern=%0b upd_idx=%0d at edge %0d, required no pulse",
                         bus.upd, bus.bad_pattern, bus.upd_idx, edge_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.upd, bus.bad_pattern} !== mon_e.kind || edge_cnt != mon_e.due ||
                    (mon_e.kind == 2'b10 &&
                     (bus.upd_idx !== mon_e.idx || bus.value[4*mon_e.idx +: 4] !== mon_e.nib))) begin
                    errors++;
                    $display("FAIL pulse: got upd/bad=%b idx=%0d nib=%h edge=%0d, required upd/bad=%b idx=%0d nib=%h edge=%0d",
                             {bus.upd, bus.bad_pattern}, bus.upd_idx, bus.value[4*mon_e.idx +: 4], edge_cnt,
                             mon_e.kind, mon_e.idx, mon_e.nib, mon_e.due);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a key at a negedge; if it will be held long enough, queue the
    // pulse it should produce and update the model.
    task automatic drive_key(input logic [ND-1:0] dig, input logic [6:0] seg, input bit will_capture);
        logic [ND+6:0] key;
        logic [5:0]    c;
        int            d;
        exp_t          e;
        key        = {dig, seg};
        bus.dig_n  = dig;
        bus.seg_n  = seg;
        d          = single_digit(dig);
        c          = classify(seg);
        if (will_capture && key != last_key && d >= 0) begin
            e.idx = 3'(d);
            e.nib = c[3:0];
            e.due = edge_cnt + S + 1;
            case (c[5:4])
                2'd0: begin
                    e.kind = 2'b10;
                    exp_q.push_back(e);
                    value_m[4*d +: 4] = c[3:0];
                    dv_m[d]           = 1'b1;
                end
                2'd1: dv_m[d] = 1'b0;
                default: begin
                    e.kind = 2'b01;
                    exp_q.push_back(e);
                    err_m = 1'b1;
                end
            endcase
        end
        last_key = key;
    endtask

    task automatic apply(input logic [ND-1:0] dig, input logic [6:0] seg, input int cycles);
        drive_key(dig, seg, cycles >= S);
        wait_cycles(cycles);
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        bus.clr     = 1'b0;
        bus.dig_n   = '1;
        bus.seg_n   = '1;
        value_m     = '0;
        dv_m        = '0;
        err_m       = 1'b0;
        last_key    = '1;
        wait_cycles(3);
        checks++;
        if ({bus.value, bus.digit_valid, bus.upd, bus.upd_idx, bus.bad_pattern, bus.err_sticky} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: value=%h dv=%b upd=%b idx=%0d bad=%b err=%b, required all zero",
                     bus.value, bus.digit_valid, bus.upd, bus.upd_idx, bus.bad_pattern, bus.err_sticky);
        end
        rst = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_hex_capture;
        apply(4'b1110, 7'b0110000, 6);
        checks++;
        if (bus.value[3:0] !== 4'h3 || bus.digit_valid !== 4'b0001) begin
            errors++;
            $display("FAIL hex_capture: value[3:0]=%h dv=%b, required 3 0001", bus.value[3:0], bus.digit_valid);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hex_capture_drain: %0d pulse(s) missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_change_before_stable;
        apply(4'b1011, 7'b1011000, 3);
        apply(4'b1011, 7'b0000010, 6);
        checks++;
        if (bus.value[11:8] !== 4'h6 || bus.digit_valid !== dv_m) begin
            errors++;
            $display("FAIL change_before_stable: value[11:8]=%h dv=%b, required 6 %b",
                     bus.value[11:8], bus.digit_valid, dv_m);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL change_before_stable_drain: %0d pulse(s) missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_blank;
        apply(4'b0111, 7'b0001000, 6);
        checks++;
        if (bus.value[15:12] !== 4'hA || bus.digit_valid[3] !== 1'b1) begin
            errors++;
            $display("FAIL blank_setup: value[15:12]=%h dv[3]=%b, required A 1", bus.value[15:12], bus.digit_valid[3]);
        end
        apply(4'b0111, 7'b1111111, 6);
        checks++;
        if (bus.value[15:12] !== 4'hA || bus.digit_valid !== dv_m || bus.err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL blank: value[15:12]=%h dv=%b err=%b, required A %b 0",
                     bus.value[15:12], bus.digit_valid, bus.err_sticky, dv_m);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL blank_drain: %0d pulse(s) missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bad_pattern;
        apply(4'b1101, 7'b1010101, 6);
        checks++;
        if (bus.err_sticky !== 1'b1 || bus.value !== value_m || bus.digit_valid !== dv_m) begin
            errors++;
            $display("FAIL bad_pattern: err=%b value=%h dv=%b, required 1 %h %b",
                     bus.err_sticky, bus.value, bus.digit_valid, value_m, dv_m);
        end
        bus.clr = 1'b1;
        wait_cycles(1);
        bus.clr = 1'b0;
        dv_m    = '0;
        err_m   = 1'b0;
        wait_cycles(1);
        checks++;
        if (bus.err_sticky !== 1'b0 || bus.digit_valid !== 4'b0000 || bus.value !== value_m) begin
            errors++;
            $display("FAIL clr: err=%b dv=%b value=%h, required 0 0000 %h",
                     bus.err_sticky, bus.digit_valid, bus.value, value_m);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bad_pattern_drain: %0d pulse(s) missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_two_digits;
        apply(4'b1100, 7'b1000000, 10);
        checks++;
        if (bus.value !== value_m || bus.digit_valid !== dv_m || bus.err_sticky !== err_m) begin
            errors++;
            $display("FAIL two_digits: value=%h dv=%b err=%b, required %h %b %b",
                     bus.value, bus.digit_valid, bus.err_sticky, value_m, dv_m, err_m);
        end
    endtask

    task automatic test_hold_long;
        apply(4'b1110, 7'b0100100, 20);
        checks++;
        if (bus.value !== value_m || bus.digit_valid !== dv_m) begin
            errors++;
            $display("FAIL hold_long: value=%h dv=%b, required %h %b", bus.value, bus.digit_valid, value_m, dv_m);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_long_drain: %0d pulse(s) missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_all_hex;
        logic [ND-1:0] dig;
        for (int n = 0; n < 16; n++) begin
            dig        = '1;
            dig[n % 4] = 1'b0;
            apply(dig, hex_seg[n], S + 2);
            checks++;
            if (bus.value[4*(n % 4) +: 4] !== 4'(n)) begin
                errors++;
                $display("FAIL all_hex_%0d: nibble=%h, required %h", n, bus.value[4*(n % 4) +: 4], 4'(n));
            end
        end
        checks++;
        if (bus.digit_valid !== 4'b1111 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL all_hex_final: dv=%b pending=%0d, required 1111 0", bus.digit_valid, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        logic [ND-1:0] dig;
        for (int k = 0; k < 8; k++) begin
            dig            = '1;
            dig[3 - k % 4] = 1'b0;
            apply(dig, hex_seg[$urandom_range(15)], S + 1);
        end
        wait_cycles(2);
        checks++;
        if (bus.value !== value_m || bus.digit_valid !== dv_m || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: value=%h dv=%b pending=%0d, required %h %b 0",
                     bus.value, bus.digit_valid, exp_q.size(), value_m, dv_m);
            exp_q.delete();
        end
    endtask

    task automatic test_clr_with_capture;
        drive_key(4'b1101, hex_seg[9], 1'b1);
        wait_cycles(S);
        bus.clr = 1'b1;
        wait_cycles(1);
        bus.clr = 1'b0;
        dv_m    = 4'b0010;
        err_m   = 1'b0;
        wait_cycles(2);
        checks++;
        if (bus.digit_valid !== 4'b0010 || bus.err_sticky !== 1'b0 || bus.value !== value_m) begin
            errors++;
            $display("FAIL clr_with_hex: dv=%b err=%b value=%h, required 0010 0 %h",
                     bus.digit_valid, bus.err_sticky, bus.value, value_m);
        end
        drive_key(4'b1011, 7'b1010101, 1'b1);
        wait_cycles(S);
        bus.clr = 1'b1;
        wait_cycles(1);
        bus.clr = 1'b0;
        dv_m    = '0;
        err_m   = 1'b1;
        wait_cycles(2);
        checks++;
        if (bus.err_sticky !== 1'b1 || bus.digit_valid !== 4'b0000 || bus.value !== value_m) begin
            errors++;
            $display("FAIL clr_with_bad: err=%b dv=%b value=%h, required 1 0000 %h",
                     bus.err_sticky, bus.digit_valid, bus.value, value_m);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL clr_with_capture_drain: %0d pulse(s) missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_track;
        drive_key(4'b1101, 7'b0011001, 1'b0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(1);
        checks++;
        if ({bus.value, bus.digit_valid, bus.upd, bus.upd_idx, bus.bad_pattern, bus.err_sticky} !== '0) begin
            errors++;
            $display("FAIL mid_track_reset: value=%h dv=%b upd=%b idx=%0d bad=%b err=%b, required all zero",
                     bus.value, bus.digit_valid, bus.upd, bus.upd_idx, bus.bad_pattern, bus.err_sticky);
        end
        wait_cycles(1);
        rst      = 1'b0;
        value_m  = '0;
        dv_m     = '0;
        err_m    = 1'b0;
        last_key = '1;
        drive_key(4'b1101, 7'b0011001, 1'b1);
        wait_cycles(S + 3);
        checks++;
        if (bus.value !== value_m || bus.digit_valid !== dv_m || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_track_recapture: value=%h dv=%b pending=%0d, required %h %b 0",
                     bus.value, bus.digit_valid, exp_q.size(), value_m, dv_m);
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_hex_capture();
        test_change_before_stable();
        test_blank();
        test_bad_pattern();
        test_two_digits();
        test_hold_long();
        test_all_hex();
        test_back_to_back();
        test_clr_with_capture();
        test_reset_mid_track();
        wait_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
